clmul_unit: RTL

CLMUL_UNIT -- requirements
Module: clmul_unit

---
 rtl/clmul_unit_pkg.sv | 37 +++
 rtl/clmul_unit_step.sv | 22 ++
 rtl/clmul_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/clmul_unit_pkg.sv
// Shared types and iteration constants for the carry-less multiply unit.
// Define CLMUL_FAST_EN to process 4 bits of rs2 per cycle instead of 1.
package clmul_unit_pkg;

  typedef enum logic [1:0] {
    CLMUL  = 2'b00,
    CLMULH = 2'b01,
    CLMULR = 2'b10,
    RSVD   = 2'b11
  } clmul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } clmul_state_e;

`ifdef CLMUL_FAST_EN
  localparam int ITER_BITS = 4;
`else
  localparam int ITER_BITS = 1;
`endif
  localparam int N_ITER = 32 / ITER_BITS;
  localparam int CNT_W  = $clog2(N_ITER);
  localparam int OFF_W  = 5;

  // Picks the architectural result out of the full 64-bit product.
  function automatic logic [31:0] clmul_select(input logic [63:0] p, input clmul_op_e op);
    case (op)
      CLMUL:   return p[31:0];
      CLMULH:  return p[63:32];
      CLMULR:  return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/clmul_unit_step.sv
// One iteration of the shift-and-xor carry-less multiply: folds ITER_BITS bits
// of the multiplier, starting at bit offset_i, into the accumulator.
module clmul_step
  import clmul_unit_pkg::*;
(
  input  logic [63:0]          acc_i,
  input  logic [31:0]          a_i,
  input  logic [ITER_BITS-1:0] b_bits_i,
  input  logic [OFF_W-1:0]     offset_i,
  output logic [63:0]          acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (b_bits_i[i]) begin
        acc_o = acc_o ^ ({32'h0, a_i} << (offset_i + OFF_W'(i)));
      end
    end
  end

endmodule

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) with a valid/ready
// issue port, a held writeback result, and flush. Speed set by CLMUL_FAST_EN.
module clmul_unit
  import clmul_unit_pkg::*;
(
  input  logic        cpu_clock_i,
  input  logic        cpu_resetn_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  op_i,
  input  logic [5:0]  tag_i,
  output logic        valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic [5:0]  tag_o,
  input  logic        flush_i
);

  clmul_state_e     state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  clmul_op_e        op_q, op_d;
  logic [5:0]       tag_q, tag_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OFF_W-1:0] offset;
  logic [63:0]      step_acc;

  assign offset = OFF_W'(cnt_q) * OFF_W'(ITER_BITS);

  clmul_step u_step (
    .acc_i    (acc_q),
    .a_i      (a_q),
    .b_bits_i (b_q[offset +: ITER_BITS]),
    .offset_i (offset),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = clmul_op_e'(op_i);
          tag_d   = tag_i;
          acc_d   = 64'h0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush outranks both acceptance and the writeback handshake.
    if (flush_i) begin
      state_d = IDLE;
      acc_d   = 64'h0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i) begin
      state_q <= IDLE;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= CLMUL;
      tag_q   <= 6'h0;
      acc_q   <= 64'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = valid_o ? clmul_select(acc_q, op_q) : 32'h0;
  assign tag_o    = tag_q;

endmodule
